// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready handshake bundle for both sides of a pipeline stage buffer
interface pipe_stage_buf_if #(parameter int DATA_W = 140);
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;
    modport master (output up_valid, up_data, dn_ready, input up_ready, dn_valid, dn_data);
    modport slave  (input up_valid, up_data, dn_ready, output up_ready, dn_valid, dn_data);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage register with 2-entry skid buffer, run/stall/bubble control,
// flush, NOP payload on empty and a saturating starvation counter
module pipe_stage_buf #(
    parameter int                DATA_W    = 140,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic             rst,
    input  logic             dclk,
    input  logic [1:0]       stl,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic              out_v, skid_v;
    logic [DATA_W-1:0] out_d, skid_d;
    logic              kill, hold, up_fire, dn_fire;

    assign kill         = flush | stl[1];
    assign hold         = (stl == 2'b01) & ~kill;
    assign bus.up_ready = ~skid_v & ~hold & ~kill;
    assign bus.dn_valid = out_v & ~hold;
    assign bus.dn_data  = out_v ? out_d : NOP_VALUE;
    assign up_fire      = bus.up_valid & bus.up_ready;
    assign dn_fire      = bus.dn_valid & bus.dn_ready;
    assign occupancy    = {1'b0, out_v} + {1'b0, skid_v};

    // skid_v implies out_v, so the occupancy cases reduce to these branches
    always_ff @(posedge dclk or posedge rst) begin
        if (rst || kill) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_d  <= NOP_VALUE;
            skid_d <= NOP_VALUE;
        end else if (!hold) begin
            if (dn_fire) begin
                if (skid_v) begin
                    out_d  <= skid_d;
                    skid_v <= 1'b0;
                    skid_d <= NOP_VALUE;
                end else if (up_fire) begin
                    out_d <= bus.up_data;
                end else begin
                    out_v <= 1'b0;
                    out_d <= NOP_VALUE;
                end
            end else if (up_fire) begin
                if (out_v) begin
                    skid_v <= 1'b1;
                    skid_d <= bus.up_data;
                end else begin
                    out_v <= 1'b1;
                    out_d <= bus.up_data;
                end
            end
        end
    end

    // starvation counter ignores kill and saturates at all-ones
    always_ff @(posedge dclk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bus.dn_ready && !bus.dn_valid && !hold && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + 1'b1;
    end
endmodule
